// File: rtl/alu_seq_unit.sv
// alu_seq_unit
// Registered ALU execution unit using the 4-bit alu_decoder op encoding.
// One operation is in flight at a time, handed over with a start/done handshake.
// Logic and add/subtract ops take one execute cycle. Signed multiply (op 10) is a
// shift-add sequence on operand magnitudes followed by a sign-fix cycle.
//
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (MUL/FIX states).
// Without it, op 10 is treated as illegal and y's upper half is sign extension only.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only while busy is low
//   op     operation code, captured with start
//   a, b   WIDTH-bit operands, captured with start
//   busy   high while an operation is in flight
//   done   one-cycle pulse; y and flags are valid from this cycle on
//   y      2*WIDTH-bit result (non-multiply results are sign-extended)
//   flag_z/flag_n/flag_c/flag_v  zero, negative, carry/borrow, signed overflow
//   err    the captured op was illegal
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c,
  output logic               flag_v,
  output logic               err
);

  localparam logic [3:0] OP_NEG  = 4'd0;
  localparam logic [3:0] OP_INV  = 4'd1;
  localparam logic [3:0] OP_ANDL = 4'd2;
  localparam logic [3:0] OP_ORL  = 4'd3;
  localparam logic [3:0] OP_EQU  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1
`ifdef ALU_SEQ_MUL_EN
    , MUL = 2'd2,
    FIX  = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH-1:0] opx;
  logic [WIDTH-1:0] opy;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   arith;
  logic             do_sub;
  logic             use_arith;
  logic             legal;
  logic             zero_y;
  logic             ex_c;
  logic             ex_v;

  // All add/subtract-style ops share one WIDTH+1 bit adder; the top bit is
  // carry for additions and borrow for subtractions. neg is computed as 0 - a.
  always_comb begin
    opx    = a_q;
    opy    = b_q;
    do_sub = 1'b0;
    case (op_q)
      OP_NEG: begin
        opx    = '0;
        opy    = a_q;
        do_sub = 1'b1;
      end
      OP_SUB, OP_CMP: do_sub = 1'b1;
      OP_INC: opy = WIDTH'(1);
      OP_DEC: begin
        opy    = WIDTH'(1);
        do_sub = 1'b1;
      end
      default: ;
    endcase

    arith = do_sub ? ({1'b0, opx} - {1'b0, opy}) : ({1'b0, opx} + {1'b0, opy});

    res       = '0;
    legal     = 1'b1;
    use_arith = 1'b0;
    zero_y    = 1'b0;
    case (op_q)
      OP_NEG, OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        res       = arith[WIDTH-1:0];
        use_arith = 1'b1;
      end
      OP_CMP: begin
        res       = arith[WIDTH-1:0];
        use_arith = 1'b1;
        zero_y    = 1'b1;
      end
      OP_INV:  res = ~a_q;
      OP_ANDL: res = a_q & b_q;
      OP_ORL:  res = a_q | b_q;
      OP_EQU:  res = (a_q == b_q) ? WIDTH'(1) : '0;
      default: legal = 1'b0;
    endcase

    ex_c = use_arith & arith[WIDTH];
    if (do_sub) begin
      ex_v = use_arith & (opx[WIDTH-1] != opy[WIDTH-1]) & (arith[WIDTH-1] != opx[WIDTH-1]);
    end else begin
      ex_v = use_arith & (opx[WIDTH-1] == opy[WIDTH-1]) & (arith[WIDTH-1] != opx[WIDTH-1]);
    end
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MULS = 4'd10;
  localparam int         CW      = $clog2(WIDTH + 1) + 1;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mplier;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic               prod_v;

  // Magnitudes need WIDTH+1 bits so that -2^(WIDTH-1) is represented exactly.
  // The product fits in signed WIDTH bits only when its top WIDTH+1 bits agree.
  always_comb begin
    mag_a    = a_q[WIDTH-1] ? ((WIDTH+1)'(0) - {1'b1, a_q}) : {1'b0, a_q};
    mag_b    = b_q[WIDTH-1] ? ((WIDTH+1)'(0) - {1'b1, b_q}) : {1'b0, b_q};
    prod     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ((2*WIDTH)'(0) - acc) : acc;
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    prod_v   = ~((&prod_top) | ~(|prod_top));
  end
`endif

  // Handshake FSM. The MUL state spends its first cycle loading the magnitudes,
  // then one shift-add step per operand bit; FIX applies the sign afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      y      <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
`ifdef ALU_SEQ_MUL_EN
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            err  <= 1'b0;
            busy <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            cnt   <= '0;
            state <= (op == OP_MULS) ? MUL : EXEC;
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          y      <= zero_y ? '0 : {{WIDTH{res[WIDTH-1]}}, res};
          flag_z <= legal & (res == '0);
          flag_n <= res[WIDTH-1];
          flag_c <= ex_c;
          flag_v <= ex_v;
          err    <= ~legal;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (cnt == '0) begin
            mcand  <= (2*WIDTH)'(mag_a);
            mplier <= mag_b;
            acc    <= '0;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (cnt == CW'(WIDTH)) begin
            state <= FIX;
          end
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          y      <= prod;
          flag_z <= (prod == '0);
          flag_n <= prod[2*WIDTH-1];
          flag_c <= 1'b0;
          flag_v <= prod_v;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
